// File: rtl/spi_reg_rx.sv
// spi_reg_rx: SPI mode-0 slave receiving 40-bit register frames; writes commit atomically at cs_n rise.
// Define SPI_READBACK_EN to enable register readback on miso.
module spi_reg_rx #(
    parameter logic [31:0] FRE_RST  = 32'd102900,
    parameter logic [31:0] SEL_RST  = 32'd1,
    parameter logic [31:0] ID_VALUE = 32'h5458_4F4B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [31:0] SPI_fre,
    output logic [31:0] SPI_sel_wave,
    output logic        upd_pulse,
    output logic        frame_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;
    logic [2:0]  sclk_s, cs_s, mosi_s;
    logic [1:0]  state;
    logic [5:0]  bit_cnt;
    logic [31:0] sr;
    logic [6:0]  addr;
    logic        rw, bad;
    logic        sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_b;
    logic [6:0]  cmd_addr;
    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign cs_fall   = ~cs_s[1] & cs_s[2];
    assign cs_rise   = cs_s[1] & ~cs_s[2];
    assign mosi_b    = mosi_s[2];
    assign cmd_addr  = {sr[5:0], mosi_b};
    // cs_n synchroniser resets low so a cs_n already low at reset release never looks like a fall
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s <= '0;
            cs_s   <= '0;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk};
            cs_s   <= {cs_s[1:0], cs_n};
            mosi_s <= {mosi_s[1:0], mosi};
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            sr           <= '0;
            addr         <= '0;
            rw           <= 1'b0;
            bad          <= 1'b0;
            SPI_fre      <= FRE_RST;
            SPI_sel_wave <= SEL_RST;
            upd_pulse    <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            upd_pulse <= 1'b0;
            frame_err <= 1'b0;
            if (cs_rise) begin
                state <= IDLE;
                if (state == CMD || state == DATA || (state == HOLD && bad))
                    frame_err <= 1'b1;
                else if (state == HOLD && !rw) begin
                    if (addr == 7'd0) SPI_fre <= sr;
                    if (addr == 7'd1) SPI_sel_wave <= sr;
                    upd_pulse <= addr < 7'd2;
                end
            end else if (state == IDLE) begin
                if (cs_fall) begin
                    bit_cnt <= '0;
                    bad     <= 1'b0;
                    state   <= CMD;
                end
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt < 6'd41 ? bit_cnt + 6'd1 : bit_cnt;
                if (state != HOLD) sr <= {sr[30:0], mosi_b};
                if (state == HOLD) bad <= 1'b1;
                if (state == CMD && bit_cnt == 6'd7) begin
                    rw    <= sr[6];
                    addr  <= cmd_addr;
                    state <= DATA;
                end
                if (state == DATA && bit_cnt == 6'd39) state <= HOLD;
            end
        end
    end
`ifdef SPI_READBACK_EN
    logic [31:0] shadow;
    assign miso_oe = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            miso   <= 1'b0;
        end else if (cs_rise) begin
            miso <= 1'b0;
        end else if (state == CMD && sclk_rise && bit_cnt == 6'd7 && sr[6]) begin
            shadow <= cmd_addr == 7'd0 ? SPI_fre :
                      cmd_addr == 7'd1 ? SPI_sel_wave :
                      cmd_addr == 7'd2 ? ID_VALUE : 32'd0;
        end else if (sclk_fall) begin
            miso   <= state == DATA && rw ? shadow[31] : 1'b0;
            shadow <= state == DATA && rw ? {shadow[30:0], 1'b0} : shadow;
        end
    end
`else
    assign miso    = 1'b0;
    assign miso_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_rx.sv
// tb_spi_reg_rx: directed SPI frames; expected register events are queued and checked by a monitor.
module tb_spi_reg_rx;
    logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic        miso, miso_oe, upd_pulse, frame_err;
    logic [31:0] SPI_fre, SPI_sel_wave;
    logic [31:0] rd;
    logic        seen;
    typedef struct packed {
        logic        err;
        logic [31:0] fre;
        logic [31:0] sel;
    } ev_t;
    ev_t exp_q[$];
    int  checks = 0, errors = 0;

    spi_reg_rx dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .SPI_fre(SPI_fre), .SPI_sel_wave(SPI_sel_wave),
        .upd_pulse(upd_pulse), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every pulse must match the oldest queued expectation; a 2-cycle pulse pops twice and fails
    always @(negedge clk) begin
        ev_t e;
        if (upd_pulse || frame_err) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got upd=%b err=%b expected none", upd_pulse, frame_err);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", {30'd0, upd_pulse, frame_err}, {30'd0, ~e.err, e.err});
                check("event_fre", SPI_fre, e.fre);
                check("event_sel", SPI_sel_wave, e.sel);
            end
        end
    end

    task automatic frame(input logic [39:0] f, input int n, input int rst_at,
                         output logic [31:0] r, output logic s);
        r = '0;
        s = 1'b0;
        cs_n = 1'b0;
        #100;
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                #40 rst = 1'b0;
            end
            mosi = i < 40 ? f[39-i] : 1'b0;
            #80 sclk = 1'b1;
            r = {r[30:0], miso};
            s = s | miso | miso_oe;
            #80 sclk = 1'b0;
        end
        #100 cs_n = 1'b1;
        #300;
        check("pending_events", exp_q.size(), 0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_fre", SPI_fre, 32'd102900);
        check("rst_sel", SPI_sel_wave, 32'd1);
        check("rst_miso_oe", {31'd0, miso_oe}, 0);
        check("rst_miso", {31'd0, miso}, 0);
        check("rst_pulses", {30'd0, upd_pulse, frame_err}, 0);

        exp_q.push_back('{err: 1'b0, fre: 32'd137200, sel: 32'd1});
        frame({1'b0, 7'h00, 32'd137200}, 40, -1, rd, seen);
        check("fre_after_write", SPI_fre, 32'd137200);
        check("sel_unchanged", SPI_sel_wave, 32'd1);

        exp_q.push_back('{err: 1'b0, fre: 32'd137200, sel: 32'd2});
        frame({1'b0, 7'h01, 32'd2}, 40, -1, rd, seen);
`ifdef SPI_READBACK_EN
        frame({1'b1, 7'h01, 32'd0}, 40, -1, rd, seen);
        check("read_sel", rd, 32'd2);
        frame({1'b1, 7'h02, 32'hFFFF_FFFF}, 40, -1, rd, seen);
        check("read_id", rd, 32'h5458_4F4B);
        frame({1'b1, 7'h05, 32'd0}, 40, -1, rd, seen);
        check("read_unmapped", rd, 32'd0);
        frame({1'b1, 7'h00, 32'd0}, 40, -1, rd, seen);
        check("read_fre", rd, 32'd137200);
`else
        frame({1'b1, 7'h02, 32'd0}, 40, -1, rd, seen);
        check("no_readback_miso", {31'd0, seen}, 0);
`endif
        exp_q.push_back('{err: 1'b1, fre: 32'd137200, sel: 32'd2});
        frame({1'b0, 7'h00, 32'd5}, 20, -1, rd, seen);
        exp_q.push_back('{err: 1'b1, fre: 32'd137200, sel: 32'd2});
        frame({1'b0, 7'h00, 32'd7}, 41, -1, rd, seen);
        frame({1'b0, 7'h02, 32'd9}, 40, -1, rd, seen);
        frame({1'b0, 7'h07, 32'd9}, 40, -1, rd, seen);
        check("fre_after_discards", SPI_fre, 32'd137200);
        check("sel_after_discards", SPI_sel_wave, 32'd2);

        frame({1'b0, 7'h01, 32'd0}, 40, 30, rd, seen);
        check("fre_after_rst", SPI_fre, 32'd102900);
        check("sel_after_rst", SPI_sel_wave, 32'd1);

        exp_q.push_back('{err: 1'b0, fre: 32'd102900, sel: 32'd3});
        frame({1'b0, 7'h01, 32'd3}, 40, -1, rd, seen);
        exp_q.push_back('{err: 1'b0, fre: 32'hDEAD_BEEF, sel: 32'd3});
        frame({1'b0, 7'h00, 32'hDEAD_BEEF}, 40, -1, rd, seen);
        check("final_fre", SPI_fre, 32'hDEAD_BEEF);
        check("final_sel", SPI_sel_wave, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
